// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline.
//   fetch_state_t : fetch FSM states (BOOT, RUN, HALT)
//   INSTR_W       : instruction / address width
//   NOP_INSTR     : encoding that decode treats as a no-op
//   PC_INC        : sequential PC step, also used by decode for PC_4
//   WORD_MASK     : clears the byte-offset bits of an address
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] PC_INC    = 32'd4;
    localparam logic [INSTR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//   clk, rst   : clock, async active-high reset
//   flush      : drop the held instruction (data kept, valid cleared)
//   load       : capture load_instr / load_pc_4 and mark valid
//   consume    : decode took the held word; clear valid
//   instr      : held instruction
//   pc_4       : address of instr + 4
//   valid      : instr is live
// Priority: flush > load > consume > hold.
module ifid_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic               consume,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [INSTR_W-1:0] load_pc_4,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] pc_4,
    output logic               valid
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= NOP_INSTR;
            pc_4  <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            instr <= load_instr;
            pc_4  <= load_pc_4;
            valid <= 1'b1;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads, fills IF/ID.
//   clk, rst          : clock, async active-high reset
//   imem_req/addr     : read request and word-aligned byte address
//   imem_ready/rdata  : same-cycle accept and returned word
//   stall             : decode cannot take a new instruction
//   redirect/target   : taken branch/jump; flush IF/ID and refetch
//   instr, PC_4       : IF/ID contents to decode
//   instr_valid       : IF/ID holds a live instruction
//   halted            : fetch stopped on the halt word
//   fetch_count       : instructions loaded into IF/ID since reset
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr,
    output logic [31:0] PC_4,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic         can_load;
    logic         hit;

    // IF/ID can take a word when it is empty or decode is draining it.
    assign can_load  = !instr_valid || !stall;
    assign hit       = imem_req && imem_ready;
    assign imem_addr = pc;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred.
    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = RUN;
        end else begin
            unique case (state)
                BOOT:    state_next = RUN;
                RUN:     if (hit && imem_rdata == HALT_INSTR) state_next = HALT;
                HALT:    state_next = HALT;
                default: state_next = BOOT;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // A redirect suppresses the request so a stale response can never load.
    always_comb begin
        imem_req = (state == RUN) && can_load && !redirect;
        halted   = (state == HALT);
    end

    // ---------------- PC and counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC & WORD_MASK;
        end else if (redirect) begin
            pc <= redirect_target & WORD_MASK;
        end else if (hit) begin
            pc <= pc + PC_INC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      fetch_count <= '0;
        else if (hit) fetch_count <= fetch_count + 32'd1;
    end

    ifid_reg u_ifid (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .load       (hit),
        .consume    (instr_valid && !stall),
        .load_instr (imem_rdata),
        .load_pc_4  (pc + PC_INC),
        .instr      (instr),
        .pc_4       (PC_4),
        .valid      (instr_valid)
    );

endmodule
